// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the single-cycle core to a wait-stated data bus.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_bus_if #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BUS_AW         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              access_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [BUS_AW-1:0] baddr_q, baddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       bwd_q, bwd_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;

    logic              access;
    logic              legal;
    logic              reject;
    logic [BUS_AW-1:0] addr_trunc;
    logic [3:0]        be_calc;
    logic [31:0]       wd_calc;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_val;

    assign access     = mem_read | mem_write;
    assign legal      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
    assign addr_trunc = BUS_AW'(addr);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign reject   = !legal || misalign;
`else
    assign reject   = !legal;
`endif

    always_comb begin
        be_calc = 4'b1111;
        wd_calc = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_calc = 4'b0001 << addr[1:0];
                wd_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc = addr[1] ? 4'b1100 : 4'b0011;
                wd_calc = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset captured at REQ entry, not the live address.
    assign ld_b = bus_rdata[{off_q, 3'b000} +: 8];
    assign ld_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (size_q)
            3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_val = {24'h0, ld_b};
            3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_val = {16'h0, ld_h};
            default: ld_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        be_d    = be_q;
        bwd_d   = bwd_q;
        size_d  = size_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (reject) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        baddr_d = addr_trunc & ~BUS_AW'(3);
                        be_d    = be_calc;
                        bwd_d   = wd_calc;
                        size_d  = funct3;
                        off_d   = addr[1:0];
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = ld_val;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= '0;
            be_q    <= '0;
            bwd_q   <= '0;
            size_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            be_q    <= be_d;
            bwd_q   <= bwd_d;
            size_q  <= size_d;
            off_q   <= off_d;
        end
    end

    // Gated by rst_n so the core is released as soon as reset asserts.
    assign stall      = rst_n && access && (state_q != DONE);
    assign rdata      = rdata_q;
    assign access_err = err_q;
    assign bus_req    = req_q;
    assign bus_we     = we_q;
    assign bus_addr   = baddr_q;
    assign bus_be     = be_q;
    assign bus_wdata  = bwd_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if: directed vector table, reset/misalign
// sequences, and randomized accesses against a behavioural model.
module tb_lsu_bus_if;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, access_err, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    lsu_bus_if #(.TIMEOUT_CYCLES(T), .BUS_AW(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .access_err(access_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          o_stall, o_req, o_err;
    logic        o_we, o_stable, o_done;
    logic [31:0] o_addr, o_bwd, o_rd;
    logic [3:0]  o_be;

    // Runs one access starting at a negedge; waits<0 means the bus never responds.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int waits,
                       input logic [31:0] rword, input logic noise);
        int idx;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ready = 1'b0; bus_rdata = rword;
        o_stall = 0; o_req = 0; o_err = 0; o_stable = 1'b1; o_done = 1'b0;
        o_be = '0; o_addr = '0; o_we = 1'b0; o_bwd = '0; o_rd = '0;
        idx = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (bus_req) begin
                if (idx == 0) begin
                    o_be = bus_be; o_addr = bus_addr; o_we = bus_we; o_bwd = bus_wdata;
                end else if (bus_be !== o_be || bus_addr !== o_addr ||
                             bus_we !== o_we || bus_wdata !== o_bwd) begin
                    o_stable = 1'b0;
                end
                bus_ready = (waits >= 0) && (idx == waits);
                bus_rdata = rword;
                idx++;
                o_req++;
            end else begin
                bus_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus_rdata = $urandom;
            end
            if (access_err) o_err++;
            if (!stall) begin
                o_done = 1'b1;
                o_rd = rdata;
                break;
            end
            o_stall++;
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0;
        if (!o_done) begin
            checks++; failures++;
            $display("FAIL run_timeout: stall never released (got stall=1 expected 0)");
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          waits;
        logic [31:0] rw;
        logic [3:0]  e_be;
        logic [31:0] e_bwd, e_rd;
        int          e_stall;
        logic        e_err, e_we;
    } vec_t;

    vec_t tv[13];

    function automatic logic [3:0] m_be(input logic [2:0] f3, input int off);
        if (f3[1:0] == 2'b00) return 4'(1 << off);
        if (f3[1:0] == 2'b01) return 4'(3 << (off & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_bwd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] word);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (f3[1:0] == 2'b01) begin
            v = (word >> (8 * (off & 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic m_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    logic [31:0] rd_model;

    initial begin
        tv[0]  = '{1, 0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF, 2,  0, 0};
        tv[1]  = '{1, 0, 3'd0, 32'h103, 32'h0,        1, 32'h80112233, 4'h8, 32'h0,        32'hFFFFFF80, 3,  0, 0};
        tv[2]  = '{1, 0, 3'd4, 32'h103, 32'h0,        0, 32'h80112233, 4'h8, 32'h0,        32'h00000080, 2,  0, 0};
        tv[3]  = '{0, 1, 3'd1, 32'h202, 32'h0000ABCD, 3, 32'h0,        4'hC, 32'hABCDABCD, 32'h00000080, 5,  0, 1};
        tv[4]  = '{1, 0, 3'd1, 32'h102, 32'h0,        0, 32'h80112233, 4'hC, 32'h0,        32'hFFFF8011, 2,  0, 0};
        tv[5]  = '{1, 0, 3'd5, 32'h100, 32'h0,        0, 32'h80112233, 4'h3, 32'h0,        32'h00002233, 2,  0, 0};
        tv[6]  = '{0, 1, 3'd0, 32'h101, 32'h0000005A, 0, 32'h0,        4'h2, 32'h5A5A5A5A, 32'h00002233, 2,  0, 1};
        tv[7]  = '{0, 1, 3'd2, 32'h300, 32'h12345678, 2, 32'h0,        4'hF, 32'h12345678, 32'h00002233, 4,  0, 1};
        tv[8]  = '{1, 0, 3'd2, 32'h104, 32'h0,       -1, 32'h0,        4'hF, 32'h0,        32'h00000000, 17, 1, 0};
        tv[9]  = '{1, 0, 3'd3, 32'h100, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h00000000, 1,  1, 0};
        tv[10] = '{1, 1, 3'd2, 32'h010, 32'hCAFEF00D, 0, 32'h11111111, 4'hF, 32'hCAFEF00D, 32'h00000000, 2,  0, 1};
        tv[11] = '{0, 1, 3'd6, 32'h100, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h00000000, 1,  1, 0};
        tv[12] = '{1, 0, 3'd2, 32'h108, 32'h0,        0, 32'h55AA55AA, 4'hF, 32'h0,        32'h55AA55AA, 2,  0, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_err", {31'h0, access_err}, 32'h0);
        chk("reset_req", {31'h0, bus_req}, 32'h0);
        chk("reset_be", {28'h0, bus_be}, 32'h0);
        chk("reset_addr", bus_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run(tv[i].rd, tv[i].wr, tv[i].f3, tv[i].a, tv[i].wd, tv[i].waits, tv[i].rw, 1'b0);
            chk($sformatf("v%0d_stall", i), o_stall, tv[i].e_stall);
            chk($sformatf("v%0d_err", i), o_err, {31'h0, tv[i].e_err});
            chk($sformatf("v%0d_rdata", i), o_rd, tv[i].e_rd);
            if (tv[i].e_be != 4'h0) begin
                chk($sformatf("v%0d_nreq", i), o_req, tv[i].e_stall - 1);
                chk($sformatf("v%0d_be", i), {28'h0, o_be}, {28'h0, tv[i].e_be});
                chk($sformatf("v%0d_addr", i), o_addr, tv[i].a & ~32'h3);
                chk($sformatf("v%0d_we", i), {31'h0, o_we}, {31'h0, tv[i].e_we});
                chk($sformatf("v%0d_stable", i), {31'h0, o_stable}, 32'h1);
                if (tv[i].e_we) chk($sformatf("v%0d_bwd", i), o_bwd, tv[i].e_bwd);
            end else begin
                chk($sformatf("v%0d_nreq", i), o_req, 0);
            end
        end

        // Reset asserted while a load waits on the bus.
        mem_read = 1'b1; funct3 = 3'd2; addr = 32'h400; bus_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_req_before", {31'h0, bus_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_err", {31'h0, access_err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_be", {28'h0, bus_be}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bwd", bus_wdata, 32'h0);
        @(negedge clk);
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'h01020304, 1'b0);
        chk("post_rst_stall", o_stall, 2);
        chk("post_rst_rdata", o_rd, 32'h01020304);
        chk("post_rst_err", o_err, 0);

        // Misaligned word load.
        run(1, 0, 3'd2, 32'h101, 32'h0, 0, 32'hA5A5A5A5, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_nreq", o_req, 0);
        chk("mis_err", o_err, 1);
        chk("mis_stall", o_stall, 1);
        chk("mis_rdata", o_rd, 32'h01020304);
`else
        chk("mis_nreq", o_req, 1);
        chk("mis_err", o_err, 0);
        chk("mis_be", {28'h0, o_be}, 32'hF);
        chk("mis_rdata", o_rd, 32'hA5A5A5A5);
`endif
        rd_model = o_rd;

        for (int n = 0; n < 200; n++) begin
            logic        rd, wr, rej;
            logic [2:0]  f3;
            logic [31:0] a, wd, rw, e_rd;
            int          waits, t, e_stall, off;
            t  = $urandom_range(0, 3);
            rd = (t != 0); wr = (t == 0) || (t == 3);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom; wd = $urandom; rw = $urandom;
            t  = $urandom_range(0, 19);
            waits = (t == 0) ? -1 : t % 5;
            off = int'(a[1:0]);
            rej = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) ||
                  m_misalign(f3, a);
            run(rd, wr, f3, a, wd, waits, rw, 1'b1);
            if (rej) begin
                e_stall = 1;
                e_rd = rd_model;
            end else if (waits < 0) begin
                e_stall = 1 + T;
                e_rd = 32'h0;
            end else begin
                e_stall = 2 + waits;
                e_rd = wr ? rd_model : m_load(f3, off, rw);
            end
            rd_model = e_rd;
            chk($sformatf("r%0d_stall", n), o_stall, e_stall);
            chk($sformatf("r%0d_err", n), o_err, (rej || waits < 0) ? 1 : 0);
            chk($sformatf("r%0d_rdata", n), o_rd, e_rd);
            chk($sformatf("r%0d_nreq", n), o_req, rej ? 0 : e_stall - 1);
            if (!rej) begin
                chk($sformatf("r%0d_be", n), {28'h0, o_be}, {28'h0, m_be(f3, off)});
                chk($sformatf("r%0d_addr", n), o_addr, a & ~32'h3);
                chk($sformatf("r%0d_we", n), {31'h0, o_we}, {31'h0, wr});
                chk($sformatf("r%0d_stable", n), {31'h0, o_stable}, 32'h1);
                if (wr) chk($sformatf("r%0d_bwd", n), o_bwd, m_bwd(f3, wd));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
